// File: rtl/pc_stack_pkg.sv
// Shared types for the PC/return-stack unit: resolved command encoding and
// circular-pointer arithmetic for the return-address stack.
package pc_stack_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_RET,
    CMD_CALL,
    CMD_BRANCH,
    CMD_INCR
  } cmd_e;

  // Step a stack pointer up or down, wrapping modulo depth (depth need not be a power of two).
  function automatic int unsigned ptr_step(input int unsigned ptr, input int unsigned depth,
                                           input bit up);
    if (up) begin
      return (ptr + 1 >= depth) ? 0 : ptr + 1;
    end
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control-unit strobes into the PC unit and the registered PC/stack status back out.
interface pc_stack_unit_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          pc_in;
  logic [N-1:0]  pc_data;
  logic          incr_pc;
  logic          branch_en;
  logic [N-1:0]  offset;
  logic          call;
  logic          ret;
  logic          err_clr;
  logic [N-1:0]  pc_out;
  logic [CW-1:0] stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  modport master (
    output pc_in, pc_data, incr_pc, branch_en, offset, call, ret, err_clr,
    input  pc_out, stack_count, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  pc_in, pc_data, incr_pc, branch_en, offset, call, ret, err_clr,
    output pc_out, stack_count, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer, optional overwrite of the
// oldest entry when full, and single-cycle overflow/underflow pulses.
module ras_stack
  import pc_stack_pkg::*;
#(
  parameter int unsigned N            = 16,
  parameter int unsigned DEPTH        = 4,
  parameter bit          WRAP_ON_FULL = 1'b0,
  localparam int unsigned CW          = $clog2(DEPTH + 1),
  localparam int unsigned PW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [N-1:0]  push_data_i,
  output logic [N-1:0]  top_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] push_ptr, pop_ptr;
  logic          full, empty, do_push, do_pop;

  always_comb begin
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    overflow_o  = push_i && full && !WRAP_ON_FULL;
    underflow_o = pop_i && empty;
    do_push     = push_i && !pop_i && !overflow_o;
    do_pop      = pop_i && !push_i && !empty;
    push_ptr    = PW'(ptr_step(32'(top_q), DEPTH, 1'b1));
    pop_ptr     = PW'(ptr_step(32'(top_q), DEPTH, 1'b0));
    top_d       = top_q;
    count_d     = count_q;
    if (do_push) begin
      // When full with wrap enabled the slot after top holds the oldest entry.
      top_d = push_ptr;
      if (!full) count_d = count_q + CW'(1);
    end else if (do_pop) begin
      top_d   = pop_ptr;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[push_ptr] <= push_data_i;
  end

  assign top_o   = mem_q[top_q];
  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with load, stepped increment, relative branch and call/return
// through an internal return-address stack; all outputs are registered.
module pc_stack_unit
  import pc_stack_pkg::*;
#(
  parameter int unsigned N            = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STEP         = 1,
  parameter int unsigned RESET_PC     = 0,
  parameter bit          WRAP_ON_FULL = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  pc_stack_unit_if.slave bus
);

  localparam int unsigned  CW       = $clog2(DEPTH + 1);
  localparam logic [N-1:0] StepN    = N'(STEP);
  localparam logic [N-1:0] ResetPcN = N'(RESET_PC);

  cmd_e          cmd;
  logic [N-1:0]  pc_q, pc_d;
  logic          err_q, err_d;
  logic [N-1:0]  ras_top;
  logic [CW-1:0] ras_count;
  logic          ras_full, ras_empty, ras_ovf, ras_unf;

  always_comb begin
    cmd = CMD_NONE;
    if      (bus.pc_in)     cmd = CMD_LOAD;
    else if (bus.ret)       cmd = CMD_RET;
    else if (bus.call)      cmd = CMD_CALL;
    else if (bus.branch_en) cmd = CMD_BRANCH;
    else if (bus.incr_pc)   cmd = CMD_INCR;
  end

  ras_stack #(
    .N            (N),
    .DEPTH        (DEPTH),
    .WRAP_ON_FULL (WRAP_ON_FULL)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cmd == CMD_CALL),
    .pop_i       (cmd == CMD_RET),
    .push_data_i (pc_q + StepN),
    .top_o       (ras_top),
    .count_o     (ras_count),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .overflow_o  (ras_ovf),
    .underflow_o (ras_unf)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (cmd)
      CMD_LOAD:   pc_d = bus.pc_data;
      CMD_RET:    if (!ras_unf) pc_d = ras_top;
      CMD_CALL:   if (!ras_ovf) pc_d = bus.pc_data;
      CMD_BRANCH: pc_d = pc_q + bus.offset;
      CMD_INCR:   pc_d = pc_q + StepN;
      default:    pc_d = pc_q;
    endcase
    // A fresh error beats a simultaneous clear.
    err_d = ras_ovf | ras_unf | (err_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= ResetPcN;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.stack_count = ras_count;
  assign bus.stack_full  = ras_full;
  assign bus.stack_empty = ras_empty;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: three parameterisations share one stimulus stream,
// and the scenario in progress selects which instance is checked.
module tb_pc_stack_unit;

  localparam logic [5:0] S_LD   = 6'b100000;
  localparam logic [5:0] S_RET  = 6'b010000;
  localparam logic [5:0] S_CALL = 6'b001000;
  localparam logic [5:0] S_BR   = 6'b000100;
  localparam logic [5:0] S_INC  = 6'b000010;
  localparam logic [5:0] S_EC   = 6'b000001;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    int          cnt;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  s = '0;
  logic [15:0] pd = '0;
  logic [15:0] offs = '0;
  int          sel = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  exp_t        e;

  logic [15:0] obs_pc    [3];
  logic [2:0]  obs_cnt   [3];
  logic        obs_full  [3];
  logic        obs_empty [3];
  logic        obs_err   [3];

  always #5 clk = ~clk;

  pc_stack_unit_if #(.N(16), .DEPTH(4)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign {bus[g].pc_in, bus[g].ret, bus[g].call, bus[g].branch_en, bus[g].incr_pc,
            bus[g].err_clr} = s;
    assign bus[g].pc_data = pd;
    assign bus[g].offset  = offs;
    assign obs_pc[g]      = bus[g].pc_out;
    assign obs_cnt[g]     = bus[g].stack_count;
    assign obs_full[g]    = bus[g].stack_full;
    assign obs_empty[g]   = bus[g].stack_empty;
    assign obs_err[g]     = bus[g].stack_err;
  end

  pc_stack_unit #(.N(16), .DEPTH(4), .STEP(2), .RESET_PC(16'h0010), .WRAP_ON_FULL(1'b0))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
  pc_stack_unit #(.N(16), .DEPTH(4), .STEP(1), .RESET_PC(0), .WRAP_ON_FULL(1'b0))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
  pc_stack_unit #(.N(16), .DEPTH(4), .STEP(1), .RESET_PC(0), .WRAP_ON_FULL(1'b1))
    u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] pc, input int cnt,
                             input bit err);
    check_eq({tag, "/pc"},    32'(obs_pc[sel]),    32'(pc));
    check_eq({tag, "/cnt"},   32'(obs_cnt[sel]),   32'(cnt));
    check_eq({tag, "/empty"}, 32'(obs_empty[sel]), 32'(cnt == 0));
    check_eq({tag, "/full"},  32'(obs_full[sel]),  32'(cnt == 4));
    check_eq({tag, "/err"},   32'(obs_err[sel]),   32'(err));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_state(e.tag, e.pc, e.cnt, e.err);
    end
  end

  task automatic op(input string tag, input logic [5:0] strobes, input logic [15:0] data,
                    input logic [15:0] off, input logic [15:0] epc, input int ecnt,
                    input bit eerr);
    exp_t x;
    @(negedge clk);
    s    = strobes;
    pd   = data;
    offs = off;
    x    = '{tag, epc, ecnt, eerr};
    exp_q.push_back(x);
    @(posedge clk);
    #2;
    s = '0;
  endtask

  task automatic do_reset(input int which, input logic [15:0] rst_pc);
    @(negedge clk);
    sel   = which;
    s     = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_state("reset", rst_pc, 0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset value and stepped increment (STEP=2, RESET_PC=0x0010)
    do_reset(0, 16'h0010);
    op("inc2_a", S_INC, 16'h0, 16'h0, 16'h0012, 0, 1'b0);
    op("inc2_b", S_INC, 16'h0, 16'h0, 16'h0014, 0, 1'b0);
    op("inc2_c", S_INC, 16'h0, 16'h0, 16'h0016, 0, 1'b0);
    op("idle",   6'b0,  16'hAAAA, 16'h5555, 16'h0016, 0, 1'b0);

    // Wrap, branch and priority (STEP=1)
    do_reset(1, 16'h0000);
    op("ld_ffff",   S_LD,  16'hFFFF, 16'h0, 16'hFFFF, 0, 1'b0);
    op("inc_wrap",  S_INC, 16'h0, 16'h0, 16'h0000, 0, 1'b0);
    op("ld_0040",   S_LD,  16'h0040, 16'h0, 16'h0040, 0, 1'b0);
    op("br_back",   S_BR,  16'h0, 16'hFFF0, 16'h0030, 0, 1'b0);
    op("br_inc",    S_BR | S_INC, 16'h0, 16'h0010, 16'h0040, 0, 1'b0);
    op("ld_br_ret", S_LD | S_BR | S_RET, 16'h1234, 16'h0004, 16'h1234, 0, 1'b0);
    op("call_inc",  S_CALL | S_INC | S_BR, 16'h2000, 16'h0008, 16'h2000, 1, 1'b0);
    op("ld_call",   S_LD | S_CALL, 16'h0100, 16'h0, 16'h0100, 1, 1'b0);
    op("ret_1",     S_RET | S_CALL, 16'h3000, 16'h0, 16'h1235, 0, 1'b0);

    // Nested calls, underflow, error clear
    op("ld_0100",   S_LD,   16'h0100, 16'h0, 16'h0100, 0, 1'b0);
    op("call_200",  S_CALL, 16'h0200, 16'h0, 16'h0200, 1, 1'b0);
    op("call_300",  S_CALL, 16'h0300, 16'h0, 16'h0300, 2, 1'b0);
    op("ret_201",   S_RET,  16'h0, 16'h0, 16'h0201, 1, 1'b0);
    op("ret_101",   S_RET,  16'h0, 16'h0, 16'h0101, 0, 1'b0);
    op("ret_unf",   S_RET,  16'h0, 16'h0, 16'h0101, 0, 1'b1);
    op("errclr",    S_EC,   16'h0, 16'h0, 16'h0101, 0, 1'b0);
    op("unf_vs_ec", S_RET | S_EC, 16'h0, 16'h0, 16'h0101, 0, 1'b1);
    op("errclr2",   S_EC,   16'h0, 16'h0, 16'h0101, 0, 1'b0);

    // Overflow rejected (WRAP_ON_FULL=0)
    do_reset(1, 16'h0000);
    for (int i = 1; i <= 4; i++)
      op("ovf_call", S_CALL, 16'(i * 16'h1000), 16'h0, 16'(i * 16'h1000), i, 1'b0);
    op("ovf_rej", S_CALL, 16'h5000, 16'h0, 16'h4000, 4, 1'b1);
    op("ovf_ret4", S_RET, 16'h0, 16'h0, 16'h3001, 3, 1'b1);
    op("ovf_ret3", S_RET, 16'h0, 16'h0, 16'h2001, 2, 1'b1);
    op("ovf_ret2", S_RET, 16'h0, 16'h0, 16'h1001, 1, 1'b1);
    op("ovf_ret1", S_RET, 16'h0, 16'h0, 16'h0001, 0, 1'b1);

    // Overflow overwrites oldest (WRAP_ON_FULL=1)
    do_reset(2, 16'h0000);
    for (int i = 1; i <= 5; i++)
      op("wrap_call", S_CALL, 16'(i * 16'h1000), 16'h0, 16'(i * 16'h1000), (i > 4) ? 4 : i,
         1'b0);
    op("wrap_ret5", S_RET, 16'h0, 16'h0, 16'h4001, 3, 1'b0);
    op("wrap_ret4", S_RET, 16'h0, 16'h0, 16'h3001, 2, 1'b0);
    op("wrap_ret3", S_RET, 16'h0, 16'h0, 16'h2001, 1, 1'b0);
    op("wrap_ret2", S_RET, 16'h0, 16'h0, 16'h1001, 0, 1'b0);
    op("wrap_unf",  S_RET, 16'h0, 16'h0, 16'h1001, 0, 1'b1);

    // Asynchronous reset between edges during a call sequence
    do_reset(1, 16'h0000);
    for (int i = 1; i <= 3; i++)
      op("ar_call", S_CALL, 16'(i * 16'h1000), 16'h0, 16'(i * 16'h1000), i, 1'b0);
    @(negedge clk);
    s  = S_CALL;
    pd = 16'h4000;
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 16'h0000, 0, 1'b0);
    s = '0;
    @(negedge clk);
    rst_n = 1'b1;
    op("ar_ret_unf", S_RET, 16'h0, 16'h0, 16'h0000, 0, 1'b1);

    repeat (2) @(negedge clk);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
